rsa_key_setup: RTL and testbench

//  Downstream consumer of prime_generator. Takes primes P, Q and public exponent E, then computes:
//  - N = P*Q; PHI = (P-1)*(Q-1)
//  - D = E^-1 mod PHI, by iterative extended Euclid (sequential divider + sequential multiplier)

---
 rtl/rsa_key_setup_if.sv | 29 ++
 rtl/rsa_key_setup.sv | 202 ++++++++++++++++++++
 tb/tb_rsa_key_setup.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/rsa_key_setup_if.sv
// rsa_key_setup_if
//   Request/result bundle between the RSA key-setup block and its driver.
//   master : drives start, P, Q, E; observes busy, done, error, N, PHI, D
//   slave  : the key-setup block itself
//   Parameter WORD_WIDTH: width of E/N/PHI/D; P and Q are WORD_WIDTH/2 bits.
interface rsa_key_setup_if #(
    parameter int WORD_WIDTH = 32
);
    logic                      start;
    logic [WORD_WIDTH/2-1:0]   P;
    logic [WORD_WIDTH/2-1:0]   Q;
    logic [WORD_WIDTH-1:0]     E;
    logic                      busy;
    logic                      done;
    logic                      error;
    logic [WORD_WIDTH-1:0]     N;
    logic [WORD_WIDTH-1:0]     PHI;
    logic [WORD_WIDTH-1:0]     D;

    modport master (
        output start, P, Q, E,
        input  busy, done, error, N, PHI, D
    );

    modport slave (
        input  start, P, Q, E,
        output busy, done, error, N, PHI, D
    );
endinterface

// File: rtl/rsa_key_setup.sv
// rsa_key_setup
//   Computes N = P*Q, PHI = (P-1)*(Q-1) and D = E^-1 mod PHI using two
//   shift-add multipliers, then an iterative extended Euclid built from a
//   restoring divider and a shift-add multiplier.
// Ports
//   clk      : rising-edge clock
//   rst      : asynchronous active-high reset, aborts any operation
//   bus      : rsa_key_setup_if.slave (start/P/Q/E in; busy/done/error/N/PHI/D out)
// Configuration
//   RSA_KEY_INPUT_CHECK_EN : when defined, the range check also rejects
//   P==Q, even P or Q, and P or Q below 3 (N and PHI are still written).
module rsa_key_setup #(
    parameter int WORD_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    rsa_key_setup_if.slave       bus
);
    localparam int HW = WORD_WIDTH / 2;
    localparam int CW = $clog2(WORD_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE, S_MUL, S_CHK, S_DIV, S_TMUL, S_UPD, S_FIN, S_DONE
    } state_t;

    state_t                r_state, w_next;
    logic [CW-1:0]         r_cnt;
    logic [WORD_WIDTH-1:0] r_e, r_n, r_phi, r_d;
    logic                  r_err;
    // N and PHI multipliers
    logic [WORD_WIDTH-1:0] r_mc_n, r_mc_phi, r_acc_n, r_acc_phi;
    logic [HW-1:0]         r_mp_n, r_mp_phi;
    // Euclid state: remainders, signed (two's complement) coefficients
    logic [WORD_WIDTH-1:0] r_r0, r_r1, r_quo, r_rem;
    logic [WORD_WIDTH:0]   r_t0, r_t1, r_mc, r_prod;
`ifdef RSA_KEY_INPUT_CHECK_EN
    logic [HW-1:0]         r_p, r_q;
`endif

    logic                  w_busy, w_done, w_accept, w_chk_bad, w_in_bad;
    logic [HW-1:0]         w_pm1, w_qm1;
    logic [WORD_WIDTH:0]   w_trial, w_diff, w_d_fix;

    assign w_accept = bus.start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_pm1    = bus.P - HW'(1);
    assign w_qm1    = bus.Q - HW'(1);

`ifdef RSA_KEY_INPUT_CHECK_EN
    assign w_in_bad = (r_p == r_q) || !r_p[0] || !r_q[0] ||
                      (r_p < HW'(3)) || (r_q < HW'(3));
`else
    assign w_in_bad = 1'b0;
`endif
    assign w_chk_bad = w_in_bad || (r_e <= WORD_WIDTH'(1)) || (r_e >= r_phi);

    // Restoring divide step: shift next dividend bit into the partial remainder
    assign w_trial = {r_rem, r_quo[WORD_WIDTH-1]};
    assign w_diff  = w_trial - {1'b0, r_r1};
    // Negative coefficient is folded back into [0, PHI)
    assign w_d_fix = r_t0[WORD_WIDTH] ? (r_t0 + {1'b0, r_phi}) : r_t0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (bus.start) w_next = S_MUL;
            S_MUL:  if (r_cnt == CW'(HW)) w_next = S_CHK;
            S_CHK:  w_next = w_chk_bad ? S_DONE : S_DIV;
            S_DIV:  if (r_cnt == CW'(WORD_WIDTH - 1)) w_next = S_TMUL;
            S_TMUL: if (r_cnt == CW'(WORD_WIDTH - 1)) w_next = S_UPD;
            S_UPD:  w_next = (r_rem == '0) ? S_FIN : S_DIV;
            S_FIN:  w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_IDLE: ;
            S_DONE: w_done = 1'b1;
            default: w_busy = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0; r_e <= '0; r_n <= '0; r_phi <= '0; r_d <= '0; r_err <= 1'b0;
            r_mc_n <= '0; r_mc_phi <= '0; r_acc_n <= '0; r_acc_phi <= '0;
            r_mp_n <= '0; r_mp_phi <= '0;
            r_r0 <= '0; r_r1 <= '0; r_quo <= '0; r_rem <= '0;
            r_t0 <= '0; r_t1 <= '0; r_mc <= '0; r_prod <= '0;
`ifdef RSA_KEY_INPUT_CHECK_EN
            r_p <= '0; r_q <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_e       <= bus.E;
                        r_err     <= 1'b0;
                        r_cnt     <= '0;
                        r_mc_n    <= WORD_WIDTH'(bus.P);
                        r_mp_n    <= bus.Q;
                        r_acc_n   <= '0;
                        r_mc_phi  <= {{HW{1'b0}}, w_pm1};
                        r_mp_phi  <= w_qm1;
                        r_acc_phi <= '0;
`ifdef RSA_KEY_INPUT_CHECK_EN
                        r_p       <= bus.P;
                        r_q       <= bus.Q;
`endif
                    end
                end
                S_MUL: begin
                    // HW shift-add steps, then one cycle to publish the products
                    if (r_cnt == CW'(HW)) begin
                        r_n   <= r_acc_n;
                        r_phi <= r_acc_phi;
                        r_cnt <= '0;
                    end else begin
                        if (r_mp_n[0])   r_acc_n   <= r_acc_n + r_mc_n;
                        if (r_mp_phi[0]) r_acc_phi <= r_acc_phi + r_mc_phi;
                        r_mc_n   <= r_mc_n << 1;
                        r_mc_phi <= r_mc_phi << 1;
                        r_mp_n   <= r_mp_n >> 1;
                        r_mp_phi <= r_mp_phi >> 1;
                        r_cnt    <= r_cnt + CW'(1);
                    end
                end
                S_CHK: begin
                    if (w_chk_bad) begin
                        r_err <= 1'b1;
                        r_d   <= '0;
                    end else begin
                        r_r0  <= r_phi;
                        r_r1  <= r_e;
                        r_t0  <= '0;
                        r_t1  <= {{WORD_WIDTH{1'b0}}, 1'b1};
                        r_quo <= r_phi;
                        r_rem <= '0;
                        r_cnt <= '0;
                    end
                end
                S_DIV: begin
                    if (!w_diff[WORD_WIDTH]) begin
                        r_rem <= w_diff[WORD_WIDTH-1:0];
                        r_quo <= {r_quo[WORD_WIDTH-2:0], 1'b1};
                    end else begin
                        r_rem <= w_trial[WORD_WIDTH-1:0];
                        r_quo <= {r_quo[WORD_WIDTH-2:0], 1'b0};
                    end
                    if (r_cnt == CW'(WORD_WIDTH - 1)) begin
                        r_cnt  <= '0;
                        r_mc   <= r_t1;
                        r_prod <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_TMUL: begin
                    // Quotient is consumed LSB-first; product wraps mod 2^(W+1)
                    if (r_quo[0]) r_prod <= r_prod + r_mc;
                    r_mc  <= r_mc << 1;
                    r_quo <= r_quo >> 1;
                    if (r_cnt == CW'(WORD_WIDTH - 1)) r_cnt <= '0;
                    else                              r_cnt <= r_cnt + CW'(1);
                end
                S_UPD: begin
                    r_r0  <= r_r1;
                    r_r1  <= r_rem;
                    r_t0  <= r_t1;
                    r_t1  <= r_t0 - r_prod;
                    r_quo <= r_r1;
                    r_rem <= '0;
                    r_cnt <= '0;
                end
                S_FIN: begin
                    if (r_r0 != WORD_WIDTH'(1)) begin
                        r_err <= 1'b1;
                        r_d   <= '0;
                    end else begin
                        r_d   <= w_d_fix[WORD_WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy  = w_busy;
    assign bus.done  = w_done;
    assign bus.error = r_err;
    assign bus.N     = r_n;
    assign bus.PHI   = r_phi;
    assign bus.D     = r_d;
endmodule

// File: tb/tb_rsa_key_setup.sv
// tb_rsa_key_setup
//   Scoreboard bench for rsa_key_setup: expected N/PHI/error (and D where it
//   is known in closed form) are queued when a request is issued and compared
//   when done rises; other D values are checked by D*E mod PHI == 1, D < PHI.
module tb_rsa_key_setup;
    localparam int W        = 32;
    localparam int CHK_LAT  = W / 2 + 2;
    localparam int MAX_CYC  = 4 * W * W + 16;

    typedef struct {
        longint unsigned n;
        longint unsigned phi;
        longint unsigned d;
        longint unsigned e;
        bit              err;
        bit              d_known;
        int              lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rsa_key_setup_if #(.WORD_WIDTH(W)) u_if ();
    rsa_key_setup #(.WORD_WIDTH(W)) u_dut (.clk(clk), .rst(rst), .bus(u_if.slave));

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    exp_t        sb[$];
    logic [15:0] lfsr = 16'h11EA;

    task automatic check_val(input string tag, input longint unsigned got,
                             input longint unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint unsigned gcd(input longint unsigned a_in,
                                            input longint unsigned b_in);
        longint unsigned a = a_in, b = b_in, t;
        while (b != 0) begin
            t = a % b; a = b; b = t;
        end
        return a;
    endfunction

    function automatic bit is_prime(input longint unsigned x);
        if (x < 2) return 1'b0;
        for (longint unsigned i = 2; i * i <= x; i++)
            if (x % i == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic longint unsigned next_prime(input logic [15:0] seed);
        longint unsigned c = {48'd0, seed | 16'h8001};
        while (!is_prime(c)) begin
            c += 2;
            if (c > 65535) c = 32769;
        end
        return c;
    endfunction

    task automatic step_lfsr();
        for (int i = 0; i < 16; i++)
            lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    endtask

    task automatic push_exp(input longint unsigned p, input longint unsigned q,
                            input longint unsigned e, input longint unsigned d,
                            input bit d_known, input int lat);
        exp_t x;
        x.n   = p * q;
        x.phi = (p - 1) * (q - 1);
        x.e   = e;
        x.err = (e <= 1) || (e >= x.phi) || (gcd(e, x.phi) != 1);
`ifdef RSA_KEY_INPUT_CHECK_EN
        if (p == q || p[0] == 1'b0 || q[0] == 1'b0 || p < 3 || q < 3) x.err = 1'b1;
`endif
        x.d       = x.err ? 0 : d;
        x.d_known = x.err ? 1'b1 : d_known;
        x.lat     = lat;
        sb.push_back(x);
    endtask

    task automatic run_key(input longint unsigned p, input longint unsigned q,
                           input longint unsigned e, input longint unsigned d,
                           input bit d_known, input int lat, input bit spurious);
        int   cyc;
        exp_t x;
        push_exp(p, q, e, d, d_known, lat);
        @(negedge clk);
        u_if.P = p[15:0]; u_if.Q = q[15:0]; u_if.E = e[31:0]; u_if.start = 1'b1;
        @(posedge clk); #1;
        u_if.start = 1'b0;
        check_val("busy_after_start", u_if.busy, 1);
        cyc = 0;
        while (!u_if.done && cyc < MAX_CYC) begin
            @(posedge clk); #1;
            cyc++;
            if (u_if.busy && u_if.done) check_val("busy_done_excl", 1, 0);
            if (spurious && cyc == 40) begin
                u_if.P = 16'd3; u_if.Q = 16'd5; u_if.E = 32'd7; u_if.start = 1'b1;
                @(posedge clk); #1;
                u_if.start = 1'b0;
                cyc++;
            end
        end
        x = sb.pop_front();
        if (!u_if.done) begin
            check_val("done_timeout", cyc, MAX_CYC + 1);
        end else begin
            check_val("busy_at_done", u_if.busy, 0);
            check_val("N", u_if.N, x.n);
            check_val("PHI", u_if.PHI, x.phi);
            check_val("error", u_if.error, x.err);
            if (x.d_known) begin
                check_val("D", u_if.D, x.d);
            end else begin
                check_val("D_inverse", (longint'(u_if.D) * x.e) % x.phi, 1);
                check_val("D_below_PHI", longint'(u_if.D) < x.phi, 1);
            end
            if (x.lat != 0) check_val("latency", cyc, x.lat);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        longint unsigned p, q;
        rst = 1'b1;
        u_if.start = 1'b0; u_if.P = '0; u_if.Q = '0; u_if.E = '0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_busy", u_if.busy, 0);
        check_val("rst_done", u_if.done, 0);
        check_val("rst_error", u_if.error, 0);
        check_val("rst_N", u_if.N, 0);
        check_val("rst_PHI", u_if.PHI, 0);
        check_val("rst_D", u_if.D, 0);
        @(negedge clk);
        rst = 1'b0;

        run_key(61, 53, 17, 2753, 1'b1, 0, 1'b0);
        run_key(11, 13, 7, 103, 1'b1, 0, 1'b1);
        run_key(7, 11, 5, 0, 1'b1, 0, 1'b0);
        run_key(61, 53, 1, 0, 1'b1, CHK_LAT, 1'b0);
        run_key(5, 7, 24, 0, 1'b1, CHK_LAT, 1'b0);
        run_key(61, 61, 17, 2753, 1'b1, 0, 1'b0);

        // Abort mid-Euclid: reset must clear everything in the same cycle
        @(negedge clk);
        u_if.P = 16'd61; u_if.Q = 16'd53; u_if.E = 32'd17; u_if.start = 1'b1;
        @(posedge clk); #1;
        u_if.start = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_val("abort_busy", u_if.busy, 0);
        check_val("abort_done", u_if.done, 0);
        check_val("abort_error", u_if.error, 0);
        check_val("abort_N", u_if.N, 0);
        check_val("abort_PHI", u_if.PHI, 0);
        check_val("abort_D", u_if.D, 0);
        @(negedge clk);
        rst = 1'b0;
        run_key(61, 53, 17, 2753, 1'b1, 0, 1'b0);

        for (int k = 0; k < 3; k++) begin
            step_lfsr();
            p = next_prime(lfsr);
            step_lfsr();
            q = next_prime(lfsr);
            if (q == p) q = next_prime(lfsr ^ 16'h0F00);
            run_key(p, q, 65537, 0, 1'b0, 0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
